// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop synchronizer feeding a 4-state FSM with a stability down-counter.
// Optional macro FALL_TICK_EN adds the db_fall_tick output and its flop.
module debounce_fsm #(
    parameter int CW        = 4,
    parameter int DB_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
`ifdef FALL_TICK_EN
    ,
    output logic db_fall_tick
`endif
);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

    logic          r_s1, r_s2;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_level, w_level_nxt;
    logic          r_tick, w_tick_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

`ifdef FALL_TICK_EN
    logic r_fall, w_fall_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fall <= 1'b0;
        else        r_fall <= w_fall_nxt;
    end

    assign db_fall_tick = r_fall;
`endif

    // Ticks default low so they last exactly one cycle after the transition edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_tick_nxt  = 1'b0;
`ifdef FALL_TICK_EN
        w_fall_nxt  = 1'b0;
`endif
        case (r_state)
            ZERO: begin
                if (r_s2) begin
                    w_state_nxt = WAIT1;
                    w_cnt_nxt   = RELOAD;
                end
            end
            WAIT1: begin
                if (!r_s2) begin
                    w_state_nxt = ZERO;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ONE;
                    w_level_nxt = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            ONE: begin
                if (!r_s2) begin
                    w_state_nxt = WAIT0;
                    w_cnt_nxt   = RELOAD;
                end
            end
            WAIT0: begin
                if (r_s2) begin
                    w_state_nxt = ONE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ZERO;
                    w_level_nxt = 1'b0;
`ifdef FALL_TICK_EN
                    w_fall_nxt  = 1'b1;
`endif
                end
            end
            default: w_state_nxt = ZERO;
        endcase
    end

    assign db_level = r_level;
    assign db_tick  = r_tick;

endmodule
